// File: rtl/sram_controller_pkg.sv
// Shared constants, state encoding and address helper for the 16-bit SRAM bridge.
package sram_controller_pkg;

  localparam int SRAM_ADDR_LEN = 18;
  localparam int SRAM_DATA_LEN = 16;
  localparam int IDX_LEN       = SRAM_ADDR_LEN - 1;

  localparam int MEM_BASE_DEFAULT = 1024;

  typedef enum logic [1:0] {
    SRAM_IDLE = 2'd0,
    SRAM_LO   = 2'd1,
    SRAM_HI   = 2'd2,
    SRAM_DONE = 2'd3
  } sram_state_e;

  // Word index relative to the SRAM window; bits above the SRAM range are dropped.
  function automatic logic [IDX_LEN-1:0] word_index(input logic [31:0] addr,
                                                    input logic [31:0] base);
    return IDX_LEN'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Core memory-stage handshake: word request, address/data and the ready/freeze signal.
interface sram_controller_if;

  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output mem_r_en, mem_w_en, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  mem_r_en, mem_w_en, addr, wdata,
    output rdata, ready
  );

endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit core access into LO/HI half-word SRAM phases and drives the SRAM pins.
// Optional macro SRAM_READ_HIT_EN adds a one-entry read-hit buffer.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int PHASE_CYCLES = 2,
  parameter int MEM_BASE     = MEM_BASE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  sram_controller_if.slave         bus,
  inout  wire  [SRAM_DATA_LEN-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
  output logic                     SRAM_WE_N,
  output logic                     SRAM_UB_N,
  output logic                     SRAM_LB_N,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_OE_N
);

  localparam logic [1:0] PHASE_LAST = 2'(PHASE_CYCLES - 1);

  sram_state_e              state_q;
  logic [1:0]               phase_q;
  logic                     is_write_q;
  logic                     drive_q;
  logic                     we_n_q;
  logic [IDX_LEN-1:0]       idx_q;
  logic [SRAM_ADDR_LEN-1:0] sram_addr_q;
  logic [15:0]              dq_out_q;
  logic [15:0]              wdata_hi_q;
  logic [31:0]              rdata_q;

  logic [IDX_LEN-1:0]       idx_d;
  logic                     req_d;
  logic                     write_d;
  logic                     phase_end_d;
  logic                     ready_d;
  logic                     hit_d;
  logic [31:0]              hit_rdata_d;

  // Decode the incoming request; a simultaneous read and write is a write.
  always_comb begin
    idx_d       = word_index(bus.addr, 32'(MEM_BASE));
    req_d       = bus.mem_r_en | bus.mem_w_en;
    write_d     = bus.mem_w_en;
    phase_end_d = (phase_q == PHASE_LAST);
  end

`ifdef SRAM_READ_HIT_EN
  logic               hit_valid_q;
  logic [IDX_LEN-1:0] hit_idx_q;
  logic [31:0]        hit_data_q;

  assign hit_d       = ~write_d & hit_valid_q & (hit_idx_q == idx_d);
  assign hit_rdata_d = hit_data_q;

  // Remember the last fully read word; a write to that index invalidates it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_valid_q <= 1'b0;
      hit_idx_q   <= '0;
      hit_data_q  <= 32'd0;
    end else if ((state_q == SRAM_IDLE) && req_d && write_d && (hit_idx_q == idx_d)) begin
      hit_valid_q <= 1'b0;
    end else if ((state_q == SRAM_HI) && phase_end_d && !is_write_q) begin
      hit_valid_q <= 1'b1;
      hit_idx_q   <= idx_q;
      hit_data_q  <= {SRAM_DQ, rdata_q[15:0]};
    end
  end
`else
  assign hit_d       = 1'b0;
  assign hit_rdata_d = 32'd0;
`endif

  // Access sequencer: phase timing, SRAM pin registers and read-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SRAM_IDLE;
      phase_q     <= 2'd0;
      is_write_q  <= 1'b0;
      drive_q     <= 1'b0;
      we_n_q      <= 1'b1;
      idx_q       <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= 16'd0;
      wdata_hi_q  <= 16'd0;
      rdata_q     <= 32'd0;
    end else begin
      case (state_q)
        SRAM_IDLE: begin
          if (req_d) begin
            idx_q      <= idx_d;
            is_write_q <= write_d;
            phase_q    <= 2'd0;
            if (hit_d) begin
              state_q <= SRAM_DONE;
              rdata_q <= hit_rdata_d;
            end else begin
              state_q     <= SRAM_LO;
              sram_addr_q <= {idx_d, 1'b0};
              we_n_q      <= ~write_d;
              drive_q     <= write_d;
              dq_out_q    <= bus.wdata[15:0];
              wdata_hi_q  <= bus.wdata[31:16];
            end
          end
        end
        SRAM_LO: begin
          if (phase_end_d) begin
            state_q     <= SRAM_HI;
            phase_q     <= 2'd0;
            sram_addr_q <= {idx_q, 1'b1};
            dq_out_q    <= wdata_hi_q;
            if (!is_write_q) begin
              rdata_q[15:0] <= SRAM_DQ;
            end
          end else begin
            phase_q <= phase_q + 2'd1;
          end
        end
        SRAM_HI: begin
          if (phase_end_d) begin
            state_q <= SRAM_DONE;
            phase_q <= 2'd0;
            we_n_q  <= 1'b1;
            drive_q <= 1'b0;
            if (!is_write_q) begin
              rdata_q[31:16] <= SRAM_DQ;
            end
          end else begin
            phase_q <= phase_q + 2'd1;
          end
        end
        SRAM_DONE: begin
          state_q <= SRAM_IDLE;
        end
        default: begin
          state_q <= SRAM_IDLE;
        end
      endcase
    end
  end

  // Ready is combinational so an idle controller never stalls a non-memory instruction.
  always_comb begin
    ready_d = 1'b0;
    case (state_q)
      SRAM_IDLE: ready_d = ~req_d;
      SRAM_DONE: ready_d = 1'b1;
      default:   ready_d = 1'b0;
    endcase
  end

  assign bus.ready  = ready_d;
  assign bus.rdata  = rdata_q;

  assign SRAM_DQ    = drive_q ? dq_out_q : {SRAM_DATA_LEN{1'bz}};
  assign SRAM_ADDR  = sram_addr_q;
  assign SRAM_WE_N  = we_n_q;
  assign SRAM_UB_N  = 1'b0;
  assign SRAM_LB_N  = 1'b0;
  assign SRAM_CE_N  = 1'b0;
  assign SRAM_OE_N  = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: SRAM behavioural model, word-level reference memory,
// a directed vector table, a reset-during-write sequence and randomized accesses.
module tb_sram_controller;

  localparam int P = 2;

  logic        clk;
  logic        rst;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

  sram_controller_if bus ();

  sram_controller #(.PHASE_CYCLES(P), .MEM_BASE(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n),
    .SRAM_UB_N (sram_ub_n),
    .SRAM_LB_N (sram_lb_n),
    .SRAM_CE_N (sram_ce_n),
    .SRAM_OE_N (sram_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: drives the bus whenever not being written; a half-word write lands
  // once the address moves on or WE_N rises normally, and is lost if reset cuts it short.
  logic [15:0] sram_mem [0:255];
  logic [7:0]  pend_a;
  logic [15:0] pend_d;
  logic        pend_v;

  assign sram_dq = sram_we_n ? sram_mem[sram_addr[7:0]] : 16'bz;

  function automatic logic [15:0] init_half(input int h);
    return 16'hA000 | 16'(h);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] <= init_half(i);
  end

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      pend_v <= 1'b0;
    end else if (!sram_we_n) begin
      if (pend_v && (pend_a != sram_addr[7:0])) sram_mem[pend_a] <= pend_d;
      pend_a <= sram_addr[7:0];
      pend_d <= sram_dq;
      pend_v <= 1'b1;
    end else if (pend_v) begin
      sram_mem[pend_a] <= pend_d;
      pend_v <= 1'b0;
    end
  end

  // Word-level reference memory and hit-buffer prediction.
  logic [31:0] ref_mem [int];
  logic        hit_v;
  int          hit_idx;

  function automatic logic [31:0] ref_read(input int idx);
    if (ref_mem.exists(idx)) return ref_mem[idx];
    return {init_half(2 * idx + 1), init_half(2 * idx)};
  endfunction

  int n_checks;
  int n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One complete core access from IDLE, checked cycle by cycle against the phase timeline.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd);
    int          idx;
    logic        hit;
    logic [31:0] exp_rd;
    logic [17:0] prev_addr;
    idx    = int'((a - 32'd1024) >> 2);
    exp_rd = ref_read(idx);
    hit    = 1'b0;
`ifdef SRAM_READ_HIT_EN
    hit = !w && r && hit_v && (hit_idx == idx);
`endif
    prev_addr    = sram_addr;
    bus.mem_r_en = r;
    bus.mem_w_en = w;
    bus.addr     = a;
    bus.wdata    = wd;
    #1;
    chk("idle_ready_low", 32'(bus.ready), 32'd0);
    if (hit) begin
      cyc();
      chk("hit_ready", 32'(bus.ready), 32'd1);
      chk("hit_rdata", bus.rdata, exp_rd);
      chk("hit_no_addr", 32'(sram_addr), 32'(prev_addr));
    end else begin
      for (int k = 0; k < 2 * P; k++) begin
        cyc();
        if (k == 0) begin
          bus.addr  = a + 32'd64;
          bus.wdata = ~wd;
        end
        chk("busy_ready", 32'(bus.ready), 32'd0);
        chk("phase_addr", 32'(sram_addr), 32'(idx * 2 + k / P));
        chk("phase_we_n", 32'(sram_we_n), w ? 32'd0 : 32'd1);
        if (w) chk("phase_dq", 32'(sram_dq), (k < P) ? 32'(wd[15:0]) : 32'(wd[31:16]));
        else   chk("read_dq_hiz", 32'(sram_dq), 32'(sram_mem[sram_addr[7:0]]));
      end
      cyc();
      chk("done_ready", 32'(bus.ready), 32'd1);
      chk("done_we_n", 32'(sram_we_n), 32'd1);
      if (!w) chk("done_rdata", bus.rdata, exp_rd);
    end
    rd = bus.rdata;
    if (w) begin
      ref_mem[idx] = wd;
      if (hit_idx == idx) hit_v = 1'b0;
    end else if (!hit) begin
      hit_v   = 1'b1;
      hit_idx = idx;
    end
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.addr     = $urandom;
    cyc();
    chk("back_idle_ready", 32'(bus.ready), 32'd1);
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] rd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    hit_v        = 1'b0;
    hit_idx      = -1;
    rst          = 1'b0;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.addr     = 32'd0;
    bus.wdata    = 32'd0;

    vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 32'd1032, 32'hAAAA5555, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hA003A002};
    vecs[4] = '{1'b1, 1'b1, 32'd1040, 32'h12345678, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'd1040, 32'h0,        32'h12345678};
    vecs[6] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hAAAA5555};
    vecs[7] = '{1'b0, 1'b1, 32'd1024, 32'h0BADF00D, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'h0BADF00D};
    vecs[9] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hA003A002};

    repeat (2) cyc();
    chk("reset_ready", 32'(bus.ready), 32'd1);
    chk("reset_we_n", 32'(sram_we_n), 32'd1);
    chk("reset_addr", 32'(sram_addr), 32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("tie_offs", {28'd0, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n}, 32'd0);
    rst = 1'b1;
    cyc();

    for (int i = 0; i < 10; i++) begin
      do_access(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].wd, rd);
      if (vecs[i].r && !vecs[i].w) chk("vec_rdata", rd, vecs[i].exp_rd);
    end

    // Reset in the HI phase of a write to 1036: the upper half-word must stay untouched.
    bus.mem_w_en = 1'b1;
    bus.addr     = 32'd1036;
    bus.wdata    = 32'hCAFE0123;
    repeat (P + 2) cyc();
    chk("rst_pre_addr", 32'(sram_addr), 32'd7);
    chk("rst_pre_we_n", 32'(sram_we_n), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_async_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_async_dq", 32'(sram_dq), 32'(sram_mem[sram_addr[7:0]]));
    bus.mem_w_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_release_ready", 32'(bus.ready), 32'd1);
    chk("rst_release_addr", 32'(sram_addr), 32'd0);
    cyc();
    chk("rst_hi_untouched", 32'(sram_mem[7]), 32'(init_half(7)));
    chk("rst_lo_written", 32'(sram_mem[6]), 32'h0123);
    ref_mem[3] = {init_half(7), 16'h0123};
    hit_v      = 1'b0;
    do_access(1'b1, 1'b0, 32'd1036, 32'h0, rd);

    // Randomized mix of reads, writes and read+write requests against the reference.
    for (int i = 0; i < 40; i++) begin
      int op;
      op = int'($urandom_range(0, 2));
      do_access(op != 1, op != 0, 32'd1024 + 32'd4 * 32'($urandom_range(0, 15)), $urandom, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Bridges the ARM core's memory stage and the external 16-bit SRAM. It turns one 32-bit word read or write into two sequential half-word SRAM accesses and drives the SRAM bus pins and the bidirectional data bus. It holds `ready` low so the core's hazard logic freezes the pipeline until the access completes.

## Interface
Parameters:
- `PHASE_CYCLES`, 2: clock cycles each half-word access is held on the bus; the SRAM runs at half the core clock. Minimum 1.
- `MEM_BASE`, 1024: byte address mapped to SRAM word 0.

Ports:
- `clk`  in  1: core clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `mem_r_en`  in  1: word read request; level, held until `ready`.
- `mem_w_en`  in  1: word write request; level, held until `ready`.
- `addr`  in  32: byte address, word-aligned.
- `wdata`  in  32: write data.
- `rdata`  out  32: read data; valid while `ready` is high in DONE.
- `ready`  out  1: access complete / controller idle; low means freeze the pipeline.
- `SRAM_DQ`  inout  `SRAM_DATA_LEN` (16): data bus.
- `SRAM_ADDR`  out  `SRAM_ADDR_LEN` (18): half-word address.
- `SRAM_WE_N`  out  1: write enable, active-low.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N`  out  1 each: tied 0.

## Operation
- Word index = (`addr` − `MEM_BASE`) >> 2. Upper bits beyond `SRAM_ADDR_LEN`−1 are truncated silently. LO half-word address = {idx, 0}. HI half-word address = {idx, 1}.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE → LO when `mem_w_en` or `mem_r_en` is sampled high.
  - LO → HI after `PHASE_CYCLES` cycles in LO.
  - HI → DONE after `PHASE_CYCLES` cycles in HI.
  - DONE → IDLE unconditionally.
- A 2-bit phase counter resets to 0 on each phase entry.
- Writes:
  - `SRAM_WE_N` = 0 throughout LO and HI.
  - `SRAM_DQ` driven with `wdata[15:0]` in LO and `wdata[31:16]` in HI.
  - `SRAM_DQ` is high-Z in all other states.
- Reads:
  - `SRAM_DQ` stays high-Z and `SRAM_WE_N` stays 1.
  - `SRAM_DQ` is captured on the last cycle of LO into `rdata[15:0]` and on the last cycle of HI into `rdata[31:16]`.
- `mem_w_en` and `mem_r_en` both high: treated as a write.
- Request and address are latched on the IDLE→LO edge. Later input changes are ignored until DONE.
- `ready` is combinational:
  - In IDLE: `ready` = ~(`mem_r_en` | `mem_w_en`).
  - In DONE: `ready` = 1.
  - In LO and HI: `ready` = 0.
- `SRAM_ADDR` is registered and holds its last value in IDLE and DONE.

## Timing
- Reset values: state IDLE, `SRAM_WE_N` = 1, `SRAM_ADDR` = 0, `SRAM_DQ` high-Z, `rdata` = 0, phase counter 0. `ready` = 1 when no request is pending.
- Latency from the request being sampled in IDLE to `ready` high: 2×`PHASE_CYCLES`+1 cycles, which is 5 at the default.
- The pipeline advances on the DONE→IDLE edge. The next request is sampled in IDLE one cycle later, so back-to-back accesses cost 2×`PHASE_CYCLES`+2 cycles each.
- Reset asserted mid-access:
  - Immediately and asynchronously: `SRAM_WE_N` → 1, `SRAM_DQ` → high-Z, state → IDLE.
  - The partial write is not completed.

## Configuration
- `SRAM_READ_HIT_EN` defined: adds a one-entry read-hit buffer (last read index + data + valid bit).
  - A read whose index matches a valid entry goes IDLE→DONE directly, with no SRAM activity; latency is 1 cycle.
  - Any write to the same index clears valid.
  - Reset clears valid.
- `SRAM_READ_HIT_EN` undefined: every read performs the full LO/HI sequence.

## Structure
- Shared constants header: `SRAM_ADDR_LEN`, `SRAM_DATA_LEN`, the state encodings `SRAM_IDLE`/`SRAM_LO`/`SRAM_HI`/`SRAM_DONE`, and the default `MEM_BASE`.
- Single module, no sub-modules. The tri-state driver is a continuous assign on `SRAM_DQ` gated by a registered write-drive flag.

## Test plan
- Write `addr`=1024, `wdata`=32'hDEADBEEF → `SRAM_ADDR` 0 with DQ 16'hBEEF for 2 cycles, then `SRAM_ADDR` 1 with DQ 16'hDEAD for 2 cycles, `WE_N` low for 4 cycles, `ready` high 5 cycles after request.
- Read `addr`=1024 after the above → DQ high-Z throughout, `rdata`=32'hDEADBEEF with `ready` high in cycle 5.
- Write `addr`=1032 then immediate read `addr`=1028 → `SRAM_ADDR` 4/5 then 2/3; no overlap of `WE_N` low with read phases.
- `rst` pulled low in HI of a write to 1036 → `WE_N`=1 and DQ high-Z asynchronously, `ready`=1 after release with no request; upper half at address 7 unchanged.
- `mem_r_en`=`mem_w_en`=1, `addr`=1040, `wdata`=32'h12345678 → write performed to half-words 8/9.
- With `SRAM_READ_HIT_EN`: read 1024 twice → second read `ready` after 1 cycle with no `SRAM_ADDR` change. Write 1024 then read again → full 5-cycle access.
